// File: rtl/sensor_conditioner_pkg.sv
// Shared definitions for the sensor front-end and the downstream threshold/relay FSM:
// state encodings and default datapath/timing parameters.
package sensor_conditioner_pkg;

    localparam int SC_W            = 12;
    localparam int SC_AVG_LOG2     = 3;
    localparam int SC_CAL_LOG2     = 4;
    localparam int SC_SETTLE_TICKS = 62;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_CALIBRATE = 2'd2,
        ST_RUN       = 2'd3
    } sc_state_e;

endpackage

// File: rtl/sen_moving_avg.sv
// Power-of-two moving average over the last 2^AVG_LOG2 raw samples, with a
// synchronous clear that empties the window and drops the outputs.
module sen_moving_avg
    import sensor_conditioner_pkg::*;
#(
    parameter int W        = SC_W,
    parameter int AVG_LOG2 = SC_AVG_LOG2
) (
    input  logic         clk_16ms,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_sen,
    output logic         o_sen_valid,
    output logic         o_full
);

    localparam int DEPTH = 2 ** AVG_LOG2;
    localparam int SW    = W + AVG_LOG2;
    localparam int FW    = AVG_LOG2 + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [W-1:0]  r_win [DEPTH];
    logic [SW-1:0] r_sum;
    logic [FW-1:0] r_fill;
    logic [W-1:0]  r_sen;
    logic          r_sen_valid;
    logic [SW-1:0] w_sum_next;
    logic [FW-1:0] w_fill_next;

    // Next running sum and fill level; the oldest sample is removed before the new one is
    // added so the intermediate never needs more than SW bits.
    always_comb begin
        w_sum_next = (r_sum - SW'(r_win[DEPTH-1])) + SW'(i_data);
        if (r_fill == FILL_MAX) begin
            w_fill_next = r_fill;
        end else begin
            w_fill_next = r_fill + FW'(1);
        end
    end

    // Window shift, running sum, filtered output and full-window pulse.
    always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
            r_sum       <= '0;
            r_fill      <= '0;
            r_sen       <= '0;
            r_sen_valid <= 1'b0;
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
            r_sum       <= '0;
            r_fill      <= '0;
            r_sen       <= '0;
            r_sen_valid <= 1'b0;
        end else if (i_valid) begin
            r_win[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_win[i] <= r_win[i-1];
            r_sum       <= w_sum_next;
            r_fill      <= w_fill_next;
            r_sen       <= w_sum_next[SW-1:AVG_LOG2];
            r_sen_valid <= (w_fill_next == FILL_MAX);
        end else begin
            r_sen_valid <= 1'b0;
        end
    end

    assign o_sen       = r_sen;
    assign o_sen_valid = r_sen_valid;
    assign o_full      = (r_fill == FILL_MAX);

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front-end: moving-average filter, settle/calibrate sequencing and the
// monitor enable that gates the threshold/relay FSM.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int W            = SC_W,
    parameter int AVG_LOG2     = SC_AVG_LOG2,
    parameter int CAL_LOG2     = SC_CAL_LOG2,
    parameter int SETTLE_TICKS = SC_SETTLE_TICKS
) (
    input  logic         clk_16ms,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_recal,
    input  logic         i_raw_valid,
    input  logic [W-1:0] i_raw_data,
    output logic [W-1:0] o_sen,
    output logic [W-1:0] o_sen_ref,
    output logic         o_sen_valid,
    output logic         o_mon_enable,
    output logic         o_cal_busy
);

    localparam int CW = $clog2(SETTLE_TICKS + 1);
    localparam int AW = W + CAL_LOG2;
    localparam int NW = CAL_LOG2 + 1;
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_TICKS);
    localparam logic [NW-1:0] CAL_LAST   = NW'((2 ** CAL_LOG2) - 1);

    sc_state_e     r_state;
    logic [CW-1:0] r_settle_cnt;
    logic [AW-1:0] r_cal_acc;
    logic [NW-1:0] r_cal_cnt;
    logic [W-1:0]  r_sen_ref;
    logic          r_mon_enable;
    logic          r_cal_busy;
    logic [W-1:0]  w_sen;
    logic          w_sen_valid;
    logic          w_full;
    logic          w_avg_clr;
    logic [AW-1:0] w_cal_sum;

    assign w_avg_clr = (r_state == ST_IDLE);
    assign w_cal_sum = r_cal_acc + AW'(w_sen);

    sen_moving_avg #(
        .W        (W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk_16ms    (clk_16ms),
        .rst         (rst),
        .i_clr       (w_avg_clr),
        .i_valid     (i_raw_valid),
        .i_data      (i_raw_data),
        .o_sen       (w_sen),
        .o_sen_valid (w_sen_valid),
        .o_full      (w_full)
    );

    // Sequencer: start is a level, so dropping it aborts any phase back to IDLE;
    // sen_ref is only written on the last calibration pulse.
    always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_cal_acc    <= '0;
            r_cal_cnt    <= '0;
            r_sen_ref    <= '0;
            r_mon_enable <= 1'b0;
            r_cal_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                        r_cal_acc    <= '0;
                        r_cal_cnt    <= '0;
                        r_cal_busy   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!i_start) begin
                        r_state    <= ST_IDLE;
                        r_cal_busy <= 1'b0;
                    end else if ((r_settle_cnt == SETTLE_END) && w_full) begin
                        r_state <= ST_CALIBRATE;
                    end else if (r_settle_cnt != SETTLE_END) begin
                        r_settle_cnt <= r_settle_cnt + CW'(1);
                    end
                end
                ST_CALIBRATE: begin
                    if (!i_start) begin
                        r_state    <= ST_IDLE;
                        r_cal_busy <= 1'b0;
                    end else if (w_sen_valid) begin
                        if (r_cal_cnt == CAL_LAST) begin
                            r_sen_ref    <= w_cal_sum[AW-1:CAL_LOG2];
                            r_state      <= ST_RUN;
                            r_mon_enable <= 1'b1;
                            r_cal_busy   <= 1'b0;
                        end else begin
                            r_cal_acc <= w_cal_sum;
                            r_cal_cnt <= r_cal_cnt + NW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!i_start) begin
                        r_state      <= ST_IDLE;
                        r_mon_enable <= 1'b0;
                    end else if (i_recal) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                        r_cal_acc    <= '0;
                        r_cal_cnt    <= '0;
                        r_mon_enable <= 1'b0;
                        r_cal_busy   <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_mon_enable <= 1'b0;
                    r_cal_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_sen        = w_sen;
    assign o_sen_ref    = r_sen_ref;
    assign o_sen_valid  = w_sen_valid;
    assign o_mon_enable = r_mon_enable;
    assign o_cal_busy   = r_cal_busy;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner: directed vector table, hand sequences
// and randomized traffic compared every cycle against a behavioural model.
module tb_sensor_conditioner;

    logic        clk_16ms;
    logic        rst;
    logic        start;
    logic        recal;
    logic        raw_valid;
    logic [11:0] raw_data;
    logic [11:0] o_sen;
    logic [11:0] o_sen_ref;
    logic        o_sen_valid;
    logic        o_mon_enable;
    logic        o_cal_busy;

    int total;
    int bad;
    bit chk_en;
    bit prev_valid;

    sensor_conditioner dut (
        .clk_16ms     (clk_16ms),
        .rst          (rst),
        .i_start      (start),
        .i_recal      (recal),
        .i_raw_valid  (raw_valid),
        .i_raw_data   (raw_data),
        .o_sen        (o_sen),
        .o_sen_ref    (o_sen_ref),
        .o_sen_valid  (o_sen_valid),
        .o_mon_enable (o_mon_enable),
        .o_cal_busy   (o_cal_busy)
    );

    initial clk_16ms = 1'b0;
    always #5 clk_16ms = ~clk_16ms;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window as a plain array averaged with integer division,
    // settle measured as elapsed ticks, calibration as a sum of collected sen values.
    int  m_win [8];
    int  m_cnt;
    int  m_sen;
    bit  m_sv;
    int  m_phase;   // 0 idle, 1 settle, 2 calibrate, 3 run
    int  m_ticks;
    int  m_cal_sum;
    int  m_cal_n;
    int  m_ref;
    bit  m_mon;
    bit  m_busy;

    always @(posedge clk_16ms or posedge rst) begin
        int lw [8];
        int lc;
        int s;
        int nsen;
        bit nsv;
        if (rst) begin
            for (int k = 0; k < 8; k++) lw[k] = 0;
            m_win <= lw; m_cnt <= 0; m_sen <= 0; m_sv <= 1'b0;
            m_phase <= 0; m_ticks <= 0; m_cal_sum <= 0; m_cal_n <= 0;
            m_ref <= 0; m_mon <= 1'b0; m_busy <= 1'b0;
        end else begin
            lw = m_win; lc = m_cnt; nsen = m_sen; nsv = 1'b0;
            if (m_phase == 0) begin
                for (int k = 0; k < 8; k++) lw[k] = 0;
                lc = 0; nsen = 0;
            end else if (raw_valid) begin
                for (int k = 7; k > 0; k--) lw[k] = lw[k-1];
                lw[0] = int'(raw_data);
                if (lc < 8) lc = lc + 1;
                s = 0;
                for (int k = 0; k < 8; k++) s = s + lw[k];
                nsen = s / 8;
                nsv = (lc == 8);
            end
            m_win <= lw; m_cnt <= lc; m_sen <= nsen; m_sv <= nsv;
            m_ticks <= m_ticks + 1;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase <= 1; m_ticks <= 0; m_cal_sum <= 0; m_cal_n <= 0; m_busy <= 1'b1;
                end
            end else if (!start) begin
                m_phase <= 0; m_mon <= 1'b0; m_busy <= 1'b0;
            end else if (m_phase == 1) begin
                if (m_ticks >= 62 && m_cnt == 8) m_phase <= 2;
            end else if (m_phase == 2) begin
                if (m_sv) begin
                    m_cal_sum <= m_cal_sum + m_sen;
                    m_cal_n   <= m_cal_n + 1;
                    if (m_cal_n + 1 == 16) begin
                        m_ref <= (m_cal_sum + m_sen) / 16;
                        m_phase <= 3; m_mon <= 1'b1; m_busy <= 1'b0;
                    end
                end
            end else if (recal) begin
                m_phase <= 1; m_ticks <= 0; m_cal_sum <= 0; m_cal_n <= 0;
                m_mon <= 1'b0; m_busy <= 1'b1;
            end
        end
    end

    always @(posedge clk_16ms) prev_valid <= raw_valid;

    // Per-cycle scoreboard against the model, sampled mid-cycle.
    always @(negedge clk_16ms) begin
        if (chk_en) begin
            check("sb_sen", int'(o_sen), m_sen);
            check("sb_sen_ref", int'(o_sen_ref), m_ref);
            check("sb_sen_valid", int'(o_sen_valid), int'(m_sv));
            check("sb_mon_enable", int'(o_mon_enable), int'(m_mon));
            check("sb_cal_busy", int'(o_cal_busy), int'(m_busy));
            check("sv_without_valid", int'(o_sen_valid && !prev_valid), 0);
        end
    end

    typedef struct {
        string name;
        bit    st;
        bit    rc;
        bit    vl;
        int    data;
        int    cyc;
        bit    chk_sen;
        int    e_sen;
        int    e_ref;
        bit    e_mon;
        bit    e_busy;
    } vec_t;

    vec_t tbl [11];

    initial begin
        chk_en = 1'b0; total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; recal = 1'b0; raw_valid = 1'b0; raw_data = 12'd0;

        tbl[0]  = '{"run_1000",    1'b1, 1'b0, 1'b1, 1000, 100, 1'b1, 1000, 1000, 1'b1, 1'b0};
        tbl[1]  = '{"recal_pulse", 1'b1, 1'b1, 1'b1, 2000,   1, 1'b0,    0, 1000, 1'b0, 1'b1};
        tbl[2]  = '{"recal_done",  1'b1, 1'b0, 1'b1, 2000, 120, 1'b1, 2000, 2000, 1'b1, 1'b0};
        tbl[3]  = '{"stop_idle",   1'b0, 1'b0, 1'b1, 2000,   2, 1'b1,    0, 2000, 1'b0, 1'b0};
        tbl[4]  = '{"run_max",     1'b1, 1'b0, 1'b1, 4095, 100, 1'b1, 4095, 4095, 1'b1, 1'b0};
        tbl[5]  = '{"step_7",      1'b1, 1'b0, 1'b1,    0,   7, 1'b1,  511, 4095, 1'b1, 1'b0};
        tbl[6]  = '{"step_8",      1'b1, 1'b0, 1'b1,    0,   1, 1'b1,    0, 4095, 1'b1, 1'b0};
        tbl[7]  = '{"idle_again",  1'b0, 1'b0, 1'b0,    0,   2, 1'b1,    0, 4095, 1'b0, 1'b0};
        tbl[8]  = '{"mid_cal",     1'b1, 1'b0, 1'b1,  500,  70, 1'b1,  500, 4095, 1'b0, 1'b1};
        tbl[9]  = '{"abort_cal",   1'b0, 1'b0, 1'b1,  500,   2, 1'b1,    0, 4095, 1'b0, 1'b0};
        tbl[10] = '{"mid_settle",  1'b1, 1'b0, 1'b1,  700,  20, 1'b1,  700, 4095, 1'b0, 1'b1};

        repeat (3) @(posedge clk_16ms);
        @(negedge clk_16ms);
        check("rst_sen", int'(o_sen), 0);
        check("rst_sen_ref", int'(o_sen_ref), 0);
        check("rst_sen_valid", int'(o_sen_valid), 0);
        check("rst_mon_enable", int'(o_mon_enable), 0);
        check("rst_cal_busy", int'(o_cal_busy), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            start = tbl[i].st; recal = tbl[i].rc; raw_valid = tbl[i].vl;
            raw_data = tbl[i].data[11:0];
            repeat (tbl[i].cyc) @(posedge clk_16ms);
            @(negedge clk_16ms);
            if (tbl[i].chk_sen) check({tbl[i].name, "_sen"}, int'(o_sen), tbl[i].e_sen);
            check({tbl[i].name, "_ref"}, int'(o_sen_ref), tbl[i].e_ref);
            check({tbl[i].name, "_mon"}, int'(o_mon_enable), int'(tbl[i].e_mon));
            check({tbl[i].name, "_busy"}, int'(o_cal_busy), int'(tbl[i].e_busy));
        end

        // Asynchronous reset in the middle of SETTLE, away from any clock edge.
        #2 rst = 1'b1;
        #1;
        check("arst_sen", int'(o_sen), 0);
        check("arst_sen_ref", int'(o_sen_ref), 0);
        check("arst_sen_valid", int'(o_sen_valid), 0);
        check("arst_mon_enable", int'(o_mon_enable), 0);
        check("arst_cal_busy", int'(o_cal_busy), 0);
        @(negedge clk_16ms);
        rst = 1'b0;

        // Ramp through a full settle/calibrate/run sequence.
        for (int i = 0; i < 150; i++) begin
            start = 1'b1; recal = 1'b0; raw_valid = 1'b1; raw_data = 12'(i * 7);
            @(negedge clk_16ms);
        end
        check("ramp_run", int'(o_mon_enable), 1);

        // Sparse samples: every 3rd cycle, then every 10th (window gates SETTLE exit).
        start = 1'b0; raw_valid = 1'b0;
        repeat (2) @(negedge clk_16ms);
        for (int i = 0; i < 200; i++) begin
            start = 1'b1; raw_valid = (i % 3 == 0); raw_data = 12'($urandom_range(0, 4095));
            @(negedge clk_16ms);
        end
        start = 1'b0; raw_valid = 1'b0;
        repeat (2) @(negedge clk_16ms);
        for (int i = 0; i < 260; i++) begin
            start = 1'b1; raw_valid = (i % 10 == 0); raw_data = 12'($urandom_range(0, 4095));
            @(negedge clk_16ms);
        end

        // Randomized traffic including recal outside RUN and recal/start-drop collisions.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 199) != 0);
            recal     = ($urandom_range(0, 79) == 0);
            raw_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: raw_data = 12'd4095;
                1: raw_data = 12'd0;
                default: raw_data = 12'($urandom_range(0, 4095));
            endcase
            @(negedge clk_16ms);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
